// File: rtl/pcie_vc_router.sv
// pcie_vc_router: ingress FIFO -> per-VC FIFOs -> arbitrated, registered destination slots.
// Define PCIE_RR_ARB_EN for round-robin VC arbitration; default is fixed lowest-index priority.
module pcie_vc_router #(
    parameter int DATA_W    = 6,
    parameter int NUM_VC    = 2,
    parameter int NUM_DEST  = 2,
    parameter int MF_DEPTH  = 4,
    parameter int VC_DEPTH  = 16,
    localparam int VC_W     = $clog2(NUM_VC),
    localparam int DEST_W   = $clog2(NUM_DEST),
    localparam int MF_CW    = $clog2(MF_DEPTH + 1),
    localparam int VC_CW    = $clog2(VC_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       init,
    input  logic [MF_CW-1:0]           umbral_mf,
    input  logic [NUM_VC*VC_CW-1:0]    umbral_vc,
    input  logic [DATA_W-1:0]          data_in_principal,
    input  logic                       push,
    input  logic [NUM_DEST-1:0]        dest_pause,
    output logic                       pausa_mf,
    output logic [NUM_VC-1:0]          pausa_vc,
    output logic [NUM_DEST*DATA_W-1:0] data_out,
    output logic [NUM_DEST-1:0]        valid_out,
    output logic                       idle_out,
    output logic                       active_out,
    output logic                       error_out
);
    // state  | meaning
    // RESET  | first cycle after reset, FIFOs empty
    // INIT   | thresholds latched every cycle while init is high
    // IDLE   | configured, no traffic in flight
    // ACTIVE | words moving through the FIFOs
    // ERROR  | ingress overflow; everything frozen until reset
    typedef enum logic [2:0] {
        ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE, ST_ERROR
    } state_t;

    localparam int MF_AW = $clog2(MF_DEPTH);
    localparam int VC_AW = $clog2(VC_DEPTH);

    state_t state, state_nxt;

    logic [DATA_W-1:0] mf_mem [MF_DEPTH];
    logic [MF_AW-1:0]  mf_wp, mf_rp;
    logic [MF_CW-1:0]  mf_cnt;

    logic [DATA_W-1:0] vc_mem [NUM_VC][VC_DEPTH];
    logic [VC_AW-1:0]  vc_wp [NUM_VC];
    logic [VC_AW-1:0]  vc_rp [NUM_VC];
    logic [VC_CW-1:0]  vc_cnt [NUM_VC];

    logic [MF_CW-1:0]        thr_mf;
    logic [NUM_VC*VC_CW-1:0] thr_vc;

    logic              run, mf_full, mf_wr, overflow, steer, all_empty, grant;
    logic [DATA_W-1:0] mf_head, win_data;
    logic [VC_W-1:0]   steer_vc, win;
    logic [DEST_W-1:0] win_dest;
    logic [DATA_W-1:0] vc_head [NUM_VC];
    logic [DEST_W-1:0] head_dest [NUM_VC];
    logic [NUM_VC-1:0] elig, vc_wr, vc_rd;

    assign run      = (state != ST_ERROR);
    assign mf_full  = (mf_cnt == MF_CW'(MF_DEPTH));
    assign mf_wr    = push && !mf_full && run;
    assign overflow = push && mf_full && run;
    assign mf_head  = mf_mem[mf_rp];
    assign steer_vc = mf_head[DATA_W-1 -: VC_W];
    // A full target VC simply holds the ingress head in place.
    assign steer    = run && (mf_cnt != '0) && (vc_cnt[steer_vc] < VC_CW'(VC_DEPTH));
    assign pausa_mf = (mf_cnt >= thr_mf);

    always_comb begin
        all_empty = (mf_cnt == '0);
        for (int v = 0; v < NUM_VC; v++) begin
            vc_head[v]   = vc_mem[v][vc_rp[v]];
            head_dest[v] = vc_head[v][DATA_W-VC_W-1 -: DEST_W];
            elig[v]      = run && (vc_cnt[v] != '0) && !dest_pause[head_dest[v]];
            pausa_vc[v]  = (vc_cnt[v] >= thr_vc[v*VC_CW +: VC_CW]);
            if (vc_cnt[v] != '0) all_empty = 1'b0;
        end
    end

`ifdef PCIE_RR_ARB_EN
    logic [VC_W-1:0] rr_ptr;
    logic [VC_W-1:0] rr_idx;

    always_comb begin
        grant  = 1'b0;
        win    = '0;
        rr_idx = '0;
        for (int k = 0; k < NUM_VC; k++) begin
            rr_idx = rr_ptr + VC_W'(k);
            if (!grant && elig[rr_idx]) begin
                grant = 1'b1;
                win   = rr_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr <= '0;
        else if (grant)
            rr_ptr <= win + VC_W'(1);
    end
`else
    always_comb begin
        grant = 1'b0;
        win   = '0;
        for (int k = NUM_VC - 1; k >= 0; k--) begin
            if (elig[k]) begin
                grant = 1'b1;
                win   = VC_W'(k);
            end
        end
    end
`endif

    assign win_data = vc_head[win];
    assign win_dest = head_dest[win];

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            vc_wr[v] = steer && (steer_vc == VC_W'(v));
            vc_rd[v] = grant && (win == VC_W'(v));
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET:  state_nxt = ST_INIT;
            ST_INIT:   if (!init) state_nxt = ST_IDLE;
            ST_IDLE:   if (push) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (all_empty && !push && (valid_out == '0)) state_nxt = ST_IDLE;
            ST_ERROR:  state_nxt = ST_ERROR;
            default:   state_nxt = ST_RESET;
        endcase
        if (run && init) state_nxt = ST_INIT;
        if (overflow)    state_nxt = ST_ERROR;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (mf_wr) mf_mem[mf_wp] <= data_in_principal;
            for (int v = 0; v < NUM_VC; v++)
                if (vc_wr[v]) vc_mem[v][vc_wp[v]] <= mf_head;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_RESET;
            mf_wp      <= '0;
            mf_rp      <= '0;
            mf_cnt     <= '0;
            thr_mf     <= '1;
            thr_vc     <= '1;
            valid_out  <= '0;
            data_out   <= '0;
            idle_out   <= 1'b0;
            active_out <= 1'b0;
            error_out  <= 1'b0;
            for (int v = 0; v < NUM_VC; v++) begin
                vc_wp[v]  <= '0;
                vc_rp[v]  <= '0;
                vc_cnt[v] <= '0;
            end
        end else begin
            state      <= state_nxt;
            idle_out   <= (state_nxt == ST_IDLE);
            active_out <= (state_nxt == ST_ACTIVE);
            error_out  <= (state_nxt == ST_ERROR);

            if (mf_wr) mf_wp <= mf_wp + MF_AW'(1);
            if (steer) mf_rp <= mf_rp + MF_AW'(1);
            mf_cnt <= mf_cnt + MF_CW'(mf_wr) - MF_CW'(steer);

            for (int v = 0; v < NUM_VC; v++) begin
                if (vc_wr[v]) vc_wp[v] <= vc_wp[v] + VC_AW'(1);
                if (vc_rd[v]) vc_rp[v] <= vc_rp[v] + VC_AW'(1);
                vc_cnt[v] <= vc_cnt[v] + VC_CW'(vc_wr[v]) - VC_CW'(vc_rd[v]);
            end

            for (int d = 0; d < NUM_DEST; d++) begin
                valid_out[d] <= grant && (win_dest == DEST_W'(d));
                if (grant && (win_dest == DEST_W'(d)))
                    data_out[d*DATA_W +: DATA_W] <= win_data;
            end

            if (state == ST_INIT) begin
                thr_mf <= umbral_mf;
                thr_vc <= umbral_vc;
            end
        end
    end

endmodule
